// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, state
// numbers, ALU/mux select codes and the per-state control word.
package mips_ctrl_pkg;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // Sequencer states; the encoding is visible on the State debug port
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADDR = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECR   = 4'd6;
  localparam logic [3:0] S_RWB     = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_EXECI   = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;
  localparam logic [3:0] S_IWB     = 4'd11;
  localparam logic [3:0] S_HALT    = 4'd12;

  // ALU operation selects
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  // ALU B-operand selects
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control word produced by the output decoder every cycle
  typedef struct packed {
    logic       pcWrite;
    logic       branchEq;
    logic       branchNe;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic [2:0] aluOp;
    logic       illegalOp;
  } ctrl_t;

  // States that sit on the memory handshake and are guarded by the timer
  function automatic logic isWaitState(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_timer.sv
// Memory wait timer: counts consecutive not-ready cycles in a memory state
// and flags a timeout once the budget is spent without MemReady.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic memReady,
  output logic timeout
);

  logic [CNT_W-1:0] waitCnt;

  // Outside a memory state the count is held at zero, so every entry into
  // a memory state starts fresh; a completed access also restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                waitCnt <= '0;
    else if (!active || memReady || timeout)  waitCnt <= '0;
    else                                      waitCnt <= waitCnt + 1'b1;
  end

  // A ready in the final cycle still completes the access, hence !memReady
  assign timeout = active && !memReady && (waitCnt >= CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: one instruction runs as 3-5 states over a
// shared ALU and unified memory; halts if memory stops answering.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       BranchEQ,
  output logic       BranchNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic       IllegalOp,
  output logic       MemFault,
  output logic [3:0] State
);

  logic [3:0] state, nextState;
  logic       timeout;
  logic       memFault;
  ctrl_t      ctrl;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) uTimer (
    .clk     (clk),
    .reset   (reset),
    .active  (isWaitState(state)),
    .memReady(MemReady),
    .timeout (timeout)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= nextState;
  end

  // Sticky fault: set on the same edge that enters HALT
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        memFault <= 1'b0;
    else if (timeout) memFault <= 1'b1;
  end

  // Next-state sequencing; timeout only fires when MemReady is low
  always_comb begin
    nextState = state;
    case (state)
      S_FETCH:   if (timeout) nextState = S_HALT; else if (MemReady) nextState = S_DECODE;
      S_DECODE: begin
        case (OP)
          OP_LW, OP_SW:     nextState = S_MEMADDR;
          OP_R:             nextState = S_EXECR;
          OP_ADDI, OP_ORI:  nextState = S_EXECI;
          OP_BEQ, OP_BNE:   nextState = S_BRANCH;
          OP_J:             nextState = S_JUMP;
          default:          nextState = S_FETCH;
        endcase
      end
      S_MEMADDR: nextState = (OP == OP_LW) ? S_MEMRD : (OP == OP_SW) ? S_MEMWR : S_FETCH;
      S_MEMRD:   if (timeout) nextState = S_HALT; else if (MemReady) nextState = S_MEMWB;
      S_MEMWB:   nextState = S_FETCH;
      S_MEMWR:   if (timeout) nextState = S_HALT; else if (MemReady) nextState = S_FETCH;
      S_EXECR:   nextState = S_RWB;
      S_RWB:     nextState = S_FETCH;
      S_BRANCH:  nextState = S_FETCH;
      S_EXECI:   nextState = S_IWB;
      S_JUMP:    nextState = S_FETCH;
      S_IWB:     nextState = S_FETCH;
      S_HALT:    nextState = S_HALT;
      default:   nextState = S_FETCH;
    endcase
  end

  // Per-state control decode; everything is forced low while reset is held
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp   = ALU_ADD;
        ctrl.irWrite = MemReady;
        ctrl.pcWrite = MemReady;
      end
      S_DECODE: begin
        ctrl.aluSrcB = SRCB_IMMSH;
        ctrl.aluOp   = ALU_ADD;
        case (OP)
          OP_LW, OP_SW, OP_R, OP_ADDI, OP_ORI, OP_BEQ, OP_BNE, OP_J: ctrl.illegalOp = 1'b0;
          default:                                                   ctrl.illegalOp = 1'b1;
        endcase
      end
      S_MEMADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memToReg = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memWrite = 1'b1;
        ctrl.iorD     = 1'b1;
      end
      S_EXECR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_RT;
        ctrl.aluOp   = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.regDst   = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA  = 1'b1;
        ctrl.aluSrcB  = SRCB_RT;
        ctrl.aluOp    = ALU_SUB;
        ctrl.pcSrc    = PCSRC_ALUOUT;
        ctrl.branchEq = (OP == OP_BEQ);
        ctrl.branchNe = (OP == OP_BNE);
      end
      S_EXECI: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = (OP == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_JUMP: begin
        ctrl.pcWrite = 1'b1;
        ctrl.pcSrc   = PCSRC_JUMP;
      end
      S_IWB: begin
        ctrl.regWrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
    if (reset) ctrl = '0;
  end

  assign PCWrite   = ctrl.pcWrite;
  assign BranchEQ  = ctrl.branchEq;
  assign BranchNE  = ctrl.branchNe;
  assign IorD      = ctrl.iorD;
  assign MemRead   = ctrl.memRead;
  assign MemWrite  = ctrl.memWrite;
  assign IRWrite   = ctrl.irWrite;
  assign MemtoReg  = ctrl.memToReg;
  assign RegDst    = ctrl.regDst;
  assign RegWrite  = ctrl.regWrite;
  assign ALUSrcA   = ctrl.aluSrcA;
  assign ALUSrcB   = ctrl.aluSrcB;
  assign PCSrc     = ctrl.pcSrc;
  assign ALUOp     = ctrl.aluOp;
  assign IllegalOp = ctrl.illegalOp;
  assign MemFault  = memFault;
  assign State     = state;

endmodule
